// File: rtl/wb_stage_pkg.sv
// Shared encodings for the mm/wb memory-access path.
package wb_stage_pkg;

  typedef enum logic [1:0] {
    MEM_ACCESS_TYPE_NONE = 2'd0,
    MEM_ACCESS_TYPE_M2R  = 2'd1,
    MEM_ACCESS_TYPE_R2R  = 2'd2,
    MEM_ACCESS_TYPE_R2M  = 2'd3
  } mem_access_t;

  typedef enum logic [1:0] {
    MEM_SIZE_BYTE = 2'd0,
    MEM_SIZE_HALF = 2'd1,
    MEM_SIZE_WORD = 2'd2,
    MEM_SIZE_RSVD = 2'd3
  } mem_size_t;

  // True for access types that retire into the register file.
  function automatic logic is_reg_write(input mem_access_t t);
    return (t == MEM_ACCESS_TYPE_M2R) || (t == MEM_ACCESS_TYPE_R2R);
  endfunction

endpackage

// File: rtl/wb_stage_if.sv
// mm -> wb request bundle plus the regfile write port and the last-write history.
interface wb_stage_if #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
);
  logic [1:0]            mem_access_type;
  logic [1:0]            mem_size;
  logic                  mem_sign;
  logic [1:0]            mem_byte_off;
  logic [DATA_W-1:0]     data_i;
  logic [REG_ADDR_W-1:0] bypass_reg_addr_mm;

  logic                  reg_write_enable;
  logic [REG_ADDR_W-1:0] reg_write_addr;
  logic [DATA_W-1:0]     reg_write_data;

  logic                  hist_valid;
  logic [REG_ADDR_W-1:0] hist_addr;
  logic [DATA_W-1:0]     hist_data;

  modport master (
    output mem_access_type, mem_size, mem_sign, mem_byte_off, data_i, bypass_reg_addr_mm,
    input  reg_write_enable, reg_write_addr, reg_write_data,
    input  hist_valid, hist_addr, hist_data
  );

  modport slave (
    input  mem_access_type, mem_size, mem_sign, mem_byte_off, data_i, bypass_reg_addr_mm,
    output reg_write_enable, reg_write_addr, reg_write_data,
    output hist_valid, hist_addr, hist_data
  );
endinterface

// File: rtl/wb_stage_load_align.sv
// Little-endian load extraction and sign/zero extension to DATA_W.
// Selection works within the low 32-bit word; DATA_W must be >= 32.
module load_align
  import wb_stage_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]        size,
  input  logic              sign,
  input  logic [1:0]        off,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte/half, then fill the upper bits with the sign rule.
  always_comb begin
    case (off)
      2'd0:    byte_sel = data[7:0];
      2'd1:    byte_sel = data[15:8];
      2'd2:    byte_sel = data[23:16];
      default: byte_sel = data[31:24];
    endcase
    half_sel = off[1] ? data[31:16] : data[15:0];

    result = '0;
    case (mem_size_t'(size))
      MEM_SIZE_BYTE: begin
        result       = {DATA_W{sign & byte_sel[7]}};
        result[7:0]  = byte_sel;
      end
      MEM_SIZE_HALF: begin
        result       = {DATA_W{sign & half_sel[15]}};
        result[15:0] = half_sel;
      end
      default: begin
        result       = {DATA_W{sign & data[31]}};
        result[31:0] = data[31:0];
      end
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: WB register, load alignment, regfile write port, last-write history.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter bit HIST_EN    = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       stall,
  input  logic       flush,
  wb_stage_if.slave  bus
);

  mem_access_t           type_q, type_d;
  logic [1:0]            size_q, size_d;
  logic                  sign_q, sign_d;
  logic [1:0]            off_q, off_d;
  logic [REG_ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0]     data_q, data_d;
  logic                  retired_q, retired_d;

  logic                  we;
  logic [DATA_W-1:0]     load_data;

  load_align #(.DATA_W(DATA_W)) u_load_align (
    .size   (size_q),
    .sign   (sign_q),
    .off    (off_q),
    .data   (data_q),
    .result (load_data)
  );

  // Write strobe: suppressed under stall so a held entry retires once, when released.
  always_comb begin
    we = is_reg_write(type_q) && (addr_q != '0) && !stall && !retired_q;
  end

  // Next WB register contents: flush beats stall, stall holds, otherwise capture mm.
  always_comb begin
    type_d    = type_q;
    size_d    = size_q;
    sign_d    = sign_q;
    off_d     = off_q;
    addr_d    = addr_q;
    data_d    = data_q;
    retired_d = retired_q;
    if (we) begin
      retired_d = 1'b1;
    end
    if (flush) begin
      type_d    = MEM_ACCESS_TYPE_NONE;
      size_d    = '0;
      sign_d    = 1'b0;
      off_d     = '0;
      addr_d    = '0;
      data_d    = '0;
      retired_d = 1'b0;
    end else if (!stall) begin
      type_d    = mem_access_t'(bus.mem_access_type);
      size_d    = bus.mem_size;
      sign_d    = bus.mem_sign;
      off_d     = bus.mem_byte_off;
      addr_d    = bus.bypass_reg_addr_mm;
      data_d    = bus.data_i;
      retired_d = 1'b0;
    end
  end

  // WB register; reset loads a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      type_q    <= MEM_ACCESS_TYPE_NONE;
      size_q    <= '0;
      sign_q    <= 1'b0;
      off_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      retired_q <= 1'b0;
    end else begin
      type_q    <= type_d;
      size_q    <= size_d;
      sign_q    <= sign_d;
      off_q     <= off_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      retired_q <= retired_d;
    end
  end

  assign bus.reg_write_enable = we;
  assign bus.reg_write_addr   = addr_q;
  assign bus.reg_write_data   = (type_q == MEM_ACCESS_TYPE_M2R) ? load_data : data_q;

  if (HIST_EN) begin : g_hist
    logic                  hist_valid_q, hist_valid_d;
    logic [REG_ADDR_W-1:0] hist_addr_q, hist_addr_d;
    logic [DATA_W-1:0]     hist_data_q, hist_data_d;

    // Track the most recent retired write; flush does not disturb it.
    always_comb begin
      hist_valid_d = hist_valid_q;
      hist_addr_d  = hist_addr_q;
      hist_data_d  = hist_data_q;
      if (we) begin
        hist_valid_d = 1'b1;
        hist_addr_d  = addr_q;
        hist_data_d  = bus.reg_write_data;
      end
    end

    // History register, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        hist_valid_q <= 1'b0;
        hist_addr_q  <= '0;
        hist_data_q  <= '0;
      end else begin
        hist_valid_q <= hist_valid_d;
        hist_addr_q  <= hist_addr_d;
        hist_data_q  <= hist_data_d;
      end
    end

    assign bus.hist_valid = hist_valid_q;
    assign bus.hist_addr  = hist_addr_q;
    assign bus.hist_data  = hist_data_q;
  end else begin : g_no_hist
    assign bus.hist_valid = 1'b0;
    assign bus.hist_addr  = '0;
    assign bus.hist_data  = '0;
  end

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: driver pushes expected writes, monitor pops on each write strobe.
module tb_wb_stage;
  import wb_stage_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic stall = 1'b0;
  logic flush = 1'b0;

  wb_stage_if #(.DATA_W(DW), .REG_ADDR_W(AW)) bus ();

  wb_stage #(.DATA_W(DW), .REG_ADDR_W(AW), .HIST_EN(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .stall (stall),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t           exp_q[$];
  int            tests = 0;
  int            fails = 0;
  bit            wb_has = 1'b0;   // model: WB currently holds a not-yet-retired write
  logic          hv = 1'b0;       // model history
  logic [AW-1:0] ha = '0;
  logic [DW-1:0] hd = '0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference load result from the byte-lane rules, in plain shift/mask arithmetic.
  function automatic logic [31:0] ref_data(input logic [1:0] t, input logic [1:0] sz,
                                           input logic sg, input logic [1:0] off,
                                           input logic [31:0] d);
    logic [31:0] v;
    if (t != MEM_ACCESS_TYPE_M2R) return d;
    if (sz == 2'd0) begin
      v = (d >> (8 * int'(off))) & 32'hFF;
      if (sg && v > 32'd127) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = (d >> (16 * (int'(off) / 2))) & 32'hFFFF;
      if (sg && v > 32'd32767) v = v | 32'hFFFF_0000;
    end else begin
      v = d;
    end
    return v;
  endfunction

  // One clock of stimulus, entered and left at posedge+1; updates the expected-write model.
  task automatic cycle(input logic st, input logic fl, input logic [1:0] t, input logic [1:0] sz,
                       input logic sg, input logic [1:0] off, input logic [DW-1:0] d,
                       input logic [AW-1:0] a, input logic [DW-1:0] exp_d);
    wr_t e;
    stall = st;
    flush = fl;
    bus.mem_access_type    = t;
    bus.mem_size           = sz;
    bus.mem_sign           = sg;
    bus.mem_byte_off       = off;
    bus.data_i             = d;
    bus.bypass_reg_addr_mm = a;
    if (fl) begin
      if (wb_has && st) void'(exp_q.pop_back());
      wb_has = 1'b0;
    end else if (!st) begin
      wb_has = ((t == MEM_ACCESS_TYPE_M2R) || (t == MEM_ACCESS_TYPE_R2R)) && (a != '0);
      if (wb_has) begin
        e.addr = a;
        e.data = exp_d;
        exp_q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_we"},    DW'(bus.reg_write_enable), '0);
    chk({tag, "_addr"},  DW'(bus.reg_write_addr),   '0);
    chk({tag, "_data"},  bus.reg_write_data,        '0);
    chk({tag, "_hv"},    DW'(bus.hist_valid),       '0);
    chk({tag, "_haddr"}, DW'(bus.hist_addr),        '0);
    chk({tag, "_hdata"}, bus.hist_data,             '0);
  endtask

  // Monitor: check history every cycle, pop and compare on each write strobe.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hv = 1'b0;
        ha = '0;
        hd = '0;
      end else begin
        chk("hist_valid", DW'(bus.hist_valid), DW'(hv));
        chk("hist_addr",  DW'(bus.hist_addr),  DW'(ha));
        chk("hist_data",  bus.hist_data,       hd);
        if (bus.reg_write_enable) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_write: got addr %0d data %h expected no write",
                     bus.reg_write_addr, bus.reg_write_data);
          end else begin
            e = exp_q.pop_front();
            chk("wr_addr", DW'(bus.reg_write_addr), DW'(e.addr));
            chk("wr_data", bus.reg_write_data, e.data);
            hv = 1'b1;
            ha = e.addr;
            hd = e.data;
          end
        end
      end
    end
  end

  // Driver: directed cases, async-reset case, then randomized traffic.
  initial begin
    logic [1:0]    t, sz, off;
    logic          sg, st, fl;
    logic [DW-1:0] d;
    logic [AW-1:0] a;

    bus.mem_access_type    = '0;
    bus.mem_size           = '0;
    bus.mem_sign           = 1'b0;
    bus.mem_byte_off       = '0;
    bus.data_i             = '0;
    bus.bypass_reg_addr_mm = '0;

    #3;
    check_all_zero("reset");
    #9;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // R2R basic, then history
    cycle(0, 0, MEM_ACCESS_TYPE_R2R, 2'd2, 0, 2'd0, 32'h1234_5678, 5'd5, 32'h1234_5678);
    cycle(0, 0, MEM_ACCESS_TYPE_NONE, 2'd0, 0, 2'd0, 32'h0, 5'd0, 32'h0);
    // byte loads
    cycle(0, 0, MEM_ACCESS_TYPE_M2R, 2'd0, 1, 2'd3, 32'h80FF_0011, 5'd6, 32'hFFFF_FF80);
    cycle(0, 0, MEM_ACCESS_TYPE_M2R, 2'd0, 0, 2'd3, 32'h80FF_0011, 5'd6, 32'h0000_0080);
    // half loads
    cycle(0, 0, MEM_ACCESS_TYPE_M2R, 2'd1, 1, 2'd2, 32'h8001_7FFF, 5'd8, 32'hFFFF_8001);
    cycle(0, 0, MEM_ACCESS_TYPE_M2R, 2'd1, 1, 2'd0, 32'h8001_7FFF, 5'd8, 32'h0000_7FFF);
    // stall holds addr 7 for three cycles, retires once
    cycle(0, 0, MEM_ACCESS_TYPE_R2R, 2'd2, 0, 2'd0, 32'hCAFE_0007, 5'd7, 32'hCAFE_0007);
    for (int i = 0; i < 3; i++)
      cycle(1, 0, MEM_ACCESS_TYPE_R2R, 2'd2, 0, 2'd0, 32'h5555_5555, 5'd11, 32'h5555_5555);
    cycle(0, 0, MEM_ACCESS_TYPE_NONE, 2'd0, 0, 2'd0, 32'h0, 5'd0, 32'h0);
    cycle(0, 0, MEM_ACCESS_TYPE_NONE, 2'd0, 0, 2'd0, 32'h0, 5'd0, 32'h0);
    // flush+stall drops pending addr 9
    cycle(0, 0, MEM_ACCESS_TYPE_R2R, 2'd2, 0, 2'd0, 32'h9999_0009, 5'd9, 32'h9999_0009);
    cycle(1, 1, MEM_ACCESS_TYPE_R2R, 2'd2, 0, 2'd0, 32'h1111_1111, 5'd12, 32'h1111_1111);
    cycle(0, 0, MEM_ACCESS_TYPE_NONE, 2'd0, 0, 2'd0, 32'h0, 5'd0, 32'h0);
    // writes to r0 never happen
    cycle(0, 0, MEM_ACCESS_TYPE_R2R, 2'd2, 0, 2'd0, 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF);
    cycle(0, 0, MEM_ACCESS_TYPE_NONE, 2'd0, 0, 2'd0, 32'h0, 5'd0, 32'h0);

    // reset asserted mid-cycle while a write is held by stall
    cycle(0, 0, MEM_ACCESS_TYPE_R2R, 2'd2, 0, 2'd0, 32'h0BAD_F00D, 5'd3, 32'h0BAD_F00D);
    stall = 1'b1;
    flush = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    if (wb_has) void'(exp_q.pop_back());
    wb_has = 1'b0;
    @(negedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      t   = 2'($urandom_range(0, 3));
      sz  = 2'($urandom_range(0, 2));
      sg  = 1'($urandom_range(0, 1));
      off = 2'($urandom_range(0, 3));
      d   = $urandom;
      a   = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom_range(1, 31));
      st  = ($urandom_range(0, 3) == 0);
      fl  = ($urandom_range(0, 9) == 0);
      cycle(st, fl, t, sz, sg, off, d, a, ref_data(t, sz, sg, off, d));
    end
    for (int i = 0; i < 3; i++)
      cycle(0, 0, MEM_ACCESS_TYPE_NONE, 2'd0, 0, 2'd0, 32'h0, 5'd0, 32'h0);

    chk("drain", DW'(exp_q.size()), '0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Parametrised writeback stage; sits between mm and the register file.
- Registers the mm result, extracts and extends load data by size and byte offset, and generates the register-file write port.
- Keeps a one-deep history of the last retired write so id can forward across the regfile write/read boundary.
- Supports stall (hold) and flush (bubble).

Parameters:
DATA_W, 32, datapath width; must be a multiple of 8
REG_ADDR_W, 5, register address width
HIST_EN, 1, 1 = build the last-write history register; 0 = hist_* outputs tied to 0

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
stall  in  1  hold the WB register; no new capture
flush  in  1  load a bubble into the WB register
mem_access_type  in  2  from mm; `MEM_ACCESS_TYPE_* encoding
mem_size  in  2  from mm; `MEM_SIZE_BYTE / _HALF / _WORD
mem_sign  in  1  1 = sign-extend load, 0 = zero-extend
mem_byte_off  in  2  address[1:0] of the access
data_i  in  DATA_W  ALU result (R2R) or raw aligned load word (M2R)
bypass_reg_addr_mm  in  REG_ADDR_W  destination register from mm
reg_write_enable  out  1  regfile write strobe
reg_write_addr  out  REG_ADDR_W  regfile write address
reg_write_data  out  DATA_W  regfile write data
hist_valid  out  1  history entry valid
hist_addr  out  REG_ADDR_W  last retired destination
hist_data  out  DATA_W  last retired data

Behaviour:
- Reset (async, rst_n=0): WB register cleared to bubble (type = `MEM_ACCESS_TYPE_NONE, addr 0, data 0); all outputs 0; history invalid.
- Capture, each posedge:
  - flush=1 loads a bubble; flush wins over stall.
  - Otherwise stall=1 holds all WB fields.
  - Otherwise mm inputs are captured.
- Latency: mm inputs are visible on reg_write_* one cycle later. Outputs are combinational from the WB register only.
- reg_write_enable = (type == M2R || type == R2R) && addr != 0. Register 0 is never written.
- Enable is also forced to 0 while stall=1, so a held instruction retires exactly once, on its last unstalled cycle.
  - Concretely: the write occurs in the first cycle the entry sits in WB with stall=0.
  - Implement with a "retired" flag, set on write and cleared on new capture.
- Load extraction (M2R only, little-endian):
  - BYTE: selects data[8*off +: 8].
  - HALF: selects data[16*off[1] +: 16]; off[0] is ignored (misalignment is trapped upstream).
  - WORD: passes the full word; off is ignored.
  - Extension: sign-extend when mem_sign=1, else zero-extend, to DATA_W.
- R2R passes data unchanged. R2M and NONE produce no write.
- History (HIST_EN=1):
  - Every cycle with reg_write_enable=1, hist_* load {1, addr, data} at the next posedge.
  - Held while no write occurs; cleared only by reset, not by flush.
  - A write whose address matches hist_addr overwrites the entry.
- Simultaneous stall and flush: flush wins.
- Reset mid-stall: bubble is loaded and the pending write is lost.
- Widths: all extension arithmetic is in DATA_W. DATA_W > 32 extends WORD loads as well, using the same sign rule.

Decomposition:
- defs.v, shared by mm and wb:
  - `MEM_SIZE_BYTE=2'd0, `MEM_SIZE_HALF=2'd1, `MEM_SIZE_WORD=2'd2
  - `MEM_ACCESS_TYPE_NONE alongside the existing M2R/R2R/R2M codes
- One combinational sub-module, load_align (size, sign, off, data -> extended data), reused later by the uncached load path.

Test Plan:
- R2R, addr 5, data 0x12345678, no stall -> next cycle we=1, addr=5, data=0x12345678; the cycle after, hist={1,5,0x12345678}.
- M2R BYTE, off=3, sign=1, data 0x80FF0011 -> write data 0xFFFFFF80; same with sign=0 -> 0x00000080.
- M2R HALF, off=2, sign=1, data 0x8001_7FFF -> 0xFFFF8001; off=0 -> 0x00007FFF.
- R2R addr 7 captured, then stall held 3 cycles -> we=0 during stall; we=1 exactly once, on the first unstalled cycle; no duplicate write.
- flush and stall asserted together with R2R addr 9 pending -> bubble, no write; hist unchanged.
- R2R addr 0, data 0xDEADBEEF -> we=0; rst_n pulsed low mid-cycle -> all outputs 0 asynchronously, before the next clock.
